// File: rtl/t_latch_pkg.sv
// Shared definitions for the t_latch toggle register bank.
package t_latch_pkg;

  // Widest legal toggle bank.
  localparam int unsigned T_LATCH_MAX_WIDTH = 64;

  // Default reset image (all cells clear), sliced down to WIDTH by the top.
  localparam logic [T_LATCH_MAX_WIDTH-1:0] T_LATCH_RESET_DEFAULT = '0;

  // Toggle/state vector at maximum width.
  typedef logic [T_LATCH_MAX_WIDTH-1:0] toggle_vec_t;

endpackage

// File: rtl/t_toggle_cell.sv
// Single T-type storage cell: inverts on a rising clk edge when t is 1.
// Synchronous active-low reset loads RESET_BIT.
module t_toggle_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next state: toggle when requested, otherwise hold.
  always_comb begin
    q_d = q_q ^ t;
  end

  // State flop; reset has priority over any toggle request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/t_latch.sv
// Bank of WIDTH independent clocked toggle cells.
// Optional feature: define T_LATCH_QN_EN to add the inverted output Qn.
module t_latch
  import t_latch_pkg::*;
#(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = T_LATCH_RESET_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] T,
`ifdef T_LATCH_QN_EN
  output logic [WIDTH-1:0] Qn,
`endif
  output logic [WIDTH-1:0] Q
);

  // Reject illegal widths at elaboration.
  if ((WIDTH == 0) || (WIDTH > T_LATCH_MAX_WIDTH)) begin : g_bad_width
    $error("t_latch: WIDTH %0d outside 1..%0d", WIDTH, T_LATCH_MAX_WIDTH);
  end

  logic [WIDTH-1:0] q_bits;

  // One cell per bit; cells never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_toggle_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (T[i]),
      .q     (q_bits[i])
    );
  end

  assign Q = q_bits;

`ifdef T_LATCH_QN_EN
  // Inverted view of the same flops; no separate state.
  assign Qn = ~q_bits;
`endif

endmodule

// File: tb/tb_t_latch.sv
// Self-checking bench for t_latch: a 1-bit instance (reset 0) and a 4-bit
// instance (reset 4'b1010). Expected values are queued as stimulus is
// driven and compared just after each rising edge.
module tb_t_latch;
  import t_latch_pkg::*;

  typedef struct {
    string       tag;
    int unsigned sel;  // 0: Q of 1-bit, 1: Q of 4-bit, 2: Qn of 1-bit, 3: Qn of 4-bit
    toggle_vec_t val;
  } exp_t;

  logic       clk;
  logic       rst_n1;
  logic       rst_n4;
  logic [0:0] t1;
  logic [3:0] t4;
  logic [0:0] q1;
  logic [3:0] q4;
`ifdef T_LATCH_QN_EN
  logic [0:0] qn1;
  logic [3:0] qn4;
`endif

  exp_t sb_q[$];
  int unsigned n_checks;
  int unsigned n_errors;

  t_latch #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .T     (t1),
`ifdef T_LATCH_QN_EN
    .Qn    (qn1),
`endif
    .Q     (q1)
  );

  t_latch #(
    .WIDTH     (4),
    .RESET_VAL (4'b1010)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n4),
    .T     (t4),
`ifdef T_LATCH_QN_EN
    .Qn    (qn4),
`endif
    .Q     (q4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input toggle_vec_t got, input toggle_vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic toggle_vec_t observe(input int unsigned sel);
    toggle_vec_t v;
    v = '0;
    case (sel)
      0: v[0:0] = q1;
      1: v[3:0] = q4;
`ifdef T_LATCH_QN_EN
      2: v[0:0] = qn1;
      3: v[3:0] = qn4;
`endif
      default: v = 'x;
    endcase
    return v;
  endfunction

  task automatic push_exp(input string tag, input int unsigned sel, input toggle_vec_t val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Advance one rising edge, then compare everything queued for it.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n1   = 1'b0;
    rst_n4   = 1'b0;
    t1       = 1'b1;
    t4       = 4'b1111;

    // Reset with T=1 held: Q stays at the reset value.
    for (int i = 0; i < 2; i++) begin
      push_exp("rst1_q", 0, 64'h0);
      push_exp("rst4_q", 1, 64'ha);
`ifdef T_LATCH_QN_EN
      push_exp("rst1_qn", 2, 64'h1);
      push_exp("rst4_qn", 3, 64'h5);
`endif
      tick();
    end

    // Release with T=0, then one hold edge.
    rst_n1 = 1'b1;
    t1     = 1'b0;
    push_exp("release1_q", 0, 64'h0);
    tick();
    push_exp("hold1_q", 0, 64'h0);
    tick();

    // Toggle train: five edges with T=1.
    t1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_exp("train1_q", 0, (i % 2 == 0) ? 64'h1 : 64'h0);
`ifdef T_LATCH_QN_EN
      push_exp("train1_qn", 2, (i % 2 == 0) ? 64'h0 : 64'h1);
`endif
      tick();
    end

    // T back to 0 for two edges: Q holds 1.
    t1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_exp("hold_after1_q", 0, 64'h1);
      tick();
    end

    // Glitch: T high only between edges (t+4 .. t+6 of a 10 ns period).
    #3;
    t1 = 1'b1;
    #1;
    check_val("glitch_mid_q", observe(0), 64'h1);
    #1;
    t1 = 1'b0;
    push_exp("glitch_edge_q", 0, 64'h1);
    tick();

    // 4-bit instance: release and toggle middle bits.
    rst_n4 = 1'b1;
    t4     = 4'b0110;
    push_exp("w4_e1_q", 1, 64'hc);
    tick();
    push_exp("w4_e2_q", 1, 64'ha);
    tick();
    push_exp("w4_e3_q", 1, 64'hc);
    tick();

    // Reset mid-toggle overrides T.
    rst_n4 = 1'b0;
    push_exp("w4_rst_q", 1, 64'ha);
`ifdef T_LATCH_QN_EN
    push_exp("w4_rst_qn", 3, 64'h5);
`endif
    tick();

    // Resume from the reset value.
    rst_n4 = 1'b1;
    t4     = 4'b0001;
    push_exp("w4_resume_q", 1, 64'hb);
    tick();

    // Bits toggle independently: all four at once.
    t4 = 4'b1111;
    push_exp("w4_all_q", 1, 64'h4);
    tick();

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
